// File: rtl/adder8_result_fifo.sv
// Result-capture FIFO behind the 8-bit adder.
// Stores each {carry, sum} result in a small show-ahead FIFO.
// Keeps saturating counts of dropped results and of accepted results
// that carried out.
module adder8_result_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_sum,
   input  logic                     in_carry,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [DATA_W:0]          out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic [CNT_W-1:0]         carry_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push;
   logic            pop;
   logic            drop;

   // Flags are decoded from the registered count only, so in_ready never
   // depends on out_ready; a full FIFO refuses a push even while popping.
   always_comb begin
      full      = (count == CW'(DEPTH));
      empty     = (count == '0);
      in_ready  = !full;
      out_valid = !empty;
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
      drop      = in_valid && !in_ready;
      out_data  = empty ? '0 : mem[rd_ptr];
   end

   // Storage write; contents need no reset because out_data is masked when empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_carry, in_sum};
      end
   end

   // Pointer and occupancy update; pointers wrap naturally as DEPTH is a power of two.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // Saturating statistics: drops on full, and accepted results with carry-out.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         drop_cnt  <= '0;
         carry_cnt <= '0;
      end else begin
         if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
         if (push && in_carry && (carry_cnt != '1)) begin
            carry_cnt <= carry_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adder8_result_fifo.sv
// Self-checking bench for adder8_result_fifo: a table of per-cycle vectors
// plus hand-written sequences for streaming, saturation and async reset.
module tb_adder8_result_fifo;

   logic       clk;
   logic       rstn;
   logic       in_valid;
   logic [7:0] in_sum;
   logic       in_carry;
   logic       in_ready;
   logic       out_valid;
   logic [8:0] out_data;
   logic       out_ready;
   logic [2:0] count;
   logic       full;
   logic       empty;
   logic [7:0] drop_cnt;
   logic [7:0] carry_cnt;

   int unsigned checks;
   int unsigned failures;

   typedef struct {
      logic        iv;
      logic [7:0]  sum;
      logic        c;
      logic        ordy;
      int unsigned e_cnt;
      logic        e_ov;
      logic [8:0]  e_od;
      logic        e_ir;
      int unsigned e_drop;
      int unsigned e_carry;
   } vec_t;

   vec_t tbl [11];

   adder8_result_fifo #(
      .DATA_W (8),
      .DEPTH  (4),
      .CNT_W  (8)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_sum    (in_sum),
      .in_carry  (in_carry),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .drop_cnt  (drop_cnt),
      .carry_cnt (carry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int unsigned e_cnt, input logic e_ov,
                            input logic [8:0] e_od, input logic e_ir,
                            input int unsigned e_drop, input int unsigned e_carry);
      chk({tag, ".count"},     32'(count),     e_cnt);
      chk({tag, ".full"},      32'(full),      32'(e_cnt == 4));
      chk({tag, ".empty"},     32'(empty),     32'(e_cnt == 0));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
      chk({tag, ".out_data"},  32'(out_data),  32'(e_od));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(e_ir));
      chk({tag, ".drop_cnt"},  32'(drop_cnt),  e_drop);
      chk({tag, ".carry_cnt"}, 32'(carry_cnt), e_carry);
   endtask

   // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
   task automatic step(input logic iv, input logic [7:0] sum, input logic c, input logic ordy);
      in_valid  = iv;
      in_sum    = sum;
      in_carry  = c;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      //          iv    sum    c     ordy  cnt ov    od      ir    drop carry
      tbl[0]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1, 1'b1, 9'h03C, 1'b1, 0, 0}; // single push
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 9'h000, 1'b1, 0, 0}; // pop -> empty
      tbl[2]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1, 1'b1, 9'h001, 1'b1, 0, 0};
      tbl[3]  = '{1'b1, 8'h02, 1'b0, 1'b0, 2, 1'b1, 9'h001, 1'b1, 0, 0};
      tbl[4]  = '{1'b1, 8'h03, 1'b0, 1'b0, 3, 1'b1, 9'h001, 1'b1, 0, 0};
      tbl[5]  = '{1'b1, 8'h04, 1'b1, 1'b0, 4, 1'b1, 9'h001, 1'b0, 0, 1}; // full
      tbl[6]  = '{1'b1, 8'h05, 1'b0, 1'b0, 4, 1'b1, 9'h001, 1'b0, 1, 1}; // drop
      tbl[7]  = '{1'b1, 8'h06, 1'b1, 1'b1, 3, 1'b1, 9'h002, 1'b1, 2, 1}; // full+pop: drop, no carry count
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b1, 9'h003, 1'b1, 2, 1};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 9'h104, 1'b1, 2, 1};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 9'h000, 1'b1, 2, 1};

      // Reset then idle
      rstn      = 1'b0;
      in_valid  = 1'b0;
      in_sum    = '0;
      in_carry  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      check_all("reset", 0, 1'b0, 9'h000, 1'b1, 0, 0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check_all("idle", 0, 1'b0, 9'h000, 1'b1, 0, 0);

      // Table-driven single result, fill/overflow, full+pop, ordered drain
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].iv, tbl[i].sum, tbl[i].c, tbl[i].ordy);
         check_all($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_ov, tbl[i].e_od,
                   tbl[i].e_ir, tbl[i].e_drop, tbl[i].e_carry);
      end

      // Streaming across the pointer wrap: simultaneous push/pop keeps count at 1
      for (int i = 0; i < 10; i++) begin
         logic [7:0] s;
         logic       c;
         s = 8'h10 + 8'(i);
         c = (i == 5);
         step(1'b1, s, c, 1'b1);
         check_all($sformatf("stream%0d", i), 1, 1'b1, {c, s}, 1'b1, 2, (i >= 5) ? 2 : 1);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check_all("stream_end", 0, 1'b0, 9'h000, 1'b1, 2, 2);

      // drop_cnt saturation
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
      end
      check_all("sat_fill", 4, 1'b1, 9'h020, 1'b0, 2, 2);
      for (int i = 0; i < 260; i++) begin
         step(1'b1, 8'hAA, 1'b1, 1'b0);
      end
      check_all("drop_sat", 4, 1'b1, 9'h020, 1'b0, 255, 2);
      for (int i = 1; i < 4; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b1);
         chk($sformatf("sat_drain%0d", i), 32'(out_data), 32'h20 + 32'(i));
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check_all("sat_drained", 0, 1'b0, 9'h000, 1'b1, 255, 2);

      // carry_cnt saturation while streaming
      for (int i = 0; i < 260; i++) begin
         step(1'b1, 8'hFF, 1'b1, 1'b1);
      end
      check_all("carry_sat", 1, 1'b1, 9'h1FF, 1'b1, 255, 255);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check_all("carry_sat_end", 0, 1'b0, 9'h000, 1'b1, 255, 255);

      // Build count=3, drop_cnt=5 from a clean reset
      #2;
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'h77, 1'b1, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check_all("pre_async", 3, 1'b1, 9'h031, 1'b1, 5, 0);

      // Async reset between edges: outputs clear with no clock edge
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      check_all("async_rst", 0, 1'b0, 9'h000, 1'b1, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      step(1'b1, 8'h55, 1'b1, 1'b0);
      check_all("post_rst_push", 1, 1'b1, 9'h155, 1'b1, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
